// File: rtl/llc_softstart_sequencer.sv
// llc_softstart_sequencer
// Start-up and protection sequencer for the LLC half-bridge hybrid controller.
// Sequence: IDLE -> PRECHARGE (gates off) -> RAMP (slew-limited phi toward the
// operator target) -> RUN (phi tracks the target at the same slew). Shoot-through,
// filtered overcurrent and filtered ADC over-range latch FAULT. The fault clears
// only after enable is dropped and a COOLDOWN interval expires.
//
// Ports:
//   i_clock       system clock
//   i_RESET       asynchronous active-low reset
//   i_enable      debounced converter enable
//   i_phi_target  unsigned operator phi target (centiradians)
//   i_iC          signed resonant current sample
//   i_alert_n     shoot-through flag, active low
//   i_adc_or      ADC out-of-range flag
//   o_phi32       phi command to the control law
//   o_gate_en     MOSFET gate enable
//   o_state       IDLE=0 PRECHARGE=1 RAMP=2 RUN=3 FAULT=4 COOLDOWN=5
//   o_fault       latched fault indicator
//   o_fault_code  0 none, 1 overcurrent, 2 shoot-through, 3 ADC over-range
module llc_softstart_sequencer #(
    parameter logic [31:0] PHI_START        = 32'd10,
    parameter logic [31:0] PHI_STEP         = 32'd1,
    parameter int          RAMP_DIV         = 100000,
    parameter int          PRECHARGE_CYCLES = 1000,
    parameter logic [13:0] I_LIMIT          = 14'd6000,
    parameter int          FAULT_FILTER     = 4,
    parameter int          COOLDOWN_CYCLES  = 100000
) (
    input  logic        i_clock,
    input  logic        i_RESET,
    input  logic        i_enable,
    input  logic [31:0] i_phi_target,
    input  logic [13:0] i_iC,
    input  logic        i_alert_n,
    input  logic        i_adc_or,
    output logic [31:0] o_phi32,
    output logic        o_gate_en,
    output logic [2:0]  o_state,
    output logic        o_fault,
    output logic [1:0]  o_fault_code
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRECHARGE = 3'd1,
        S_RAMP      = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4,
        S_COOLDOWN  = 3'd5
    } state_t;

    // One shared cycle counter serves precharge, ramp ticks and cooldown,
    // so it is sized for the longest of the three intervals.
    localparam int MAX_AB = (RAMP_DIV > PRECHARGE_CYCLES) ? RAMP_DIV : PRECHARGE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > COOLDOWN_CYCLES) ? MAX_AB : COOLDOWN_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam int FLT_W = $clog2(FAULT_FILTER + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRECHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FAULT_FILTER - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FLT_W-1:0]  oc_cnt_q, oc_cnt_d;
    logic [FLT_W-1:0]  or_cnt_q, or_cnt_d;
    logic [31:0]       phi_q, phi_d;
    logic [1:0]        code_q, code_d;
    logic              gate_q, gate_d;
    logic              fault_q, fault_d;

    logic [13:0]       ic_mag;
    logic              active, tick, oc_hit, st_fault, oc_fault, or_fault;
    logic [32:0]       ramp_sum, diff;
    logic [31:0]       diff_mag;

    // |iC| with -8192 saturating to 8191 so the magnitude stays in 14 bits.
    always_comb begin
        if (i_iC[13]) begin
            ic_mag = (i_iC == 14'h2000) ? 14'h1FFF : (~i_iC + 14'd1);
        end else begin
            ic_mag = i_iC;
        end
    end

    // Phi arithmetic is done in 33 bits so steps near the 32-bit limits
    // neither wrap nor overshoot the target.
    assign ramp_sum = {1'b0, phi_q} + {1'b0, PHI_STEP};
    assign diff     = {1'b0, i_phi_target} - {1'b0, phi_q};
    assign diff_mag = diff[32] ? (~diff[31:0] + 32'd1) : diff[31:0];

    assign active   = (state_q == S_PRECHARGE) || (state_q == S_RAMP) || (state_q == S_RUN);
    assign tick     = (cnt_q == TICK_LAST);
    assign oc_hit   = (ic_mag > I_LIMIT);
    assign st_fault = active && !i_alert_n;
    assign oc_fault = active && oc_hit && (oc_cnt_q == FLT_LAST);
    assign or_fault = active && i_adc_or && (or_cnt_q == FLT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phi_d    = phi_q;
        code_d   = code_q;
        oc_cnt_d = '0;
        or_cnt_d = '0;

        // Filters only run while the converter is being driven.
        if (active) begin
            oc_cnt_d = oc_hit   ? (oc_cnt_q + FLT_W'(1)) : '0;
            or_cnt_d = i_adc_or ? (or_cnt_q + FLT_W'(1)) : '0;
        end

        case (state_q)
            S_IDLE: begin
                phi_d = PHI_START;
                cnt_d = '0;
                if (i_enable) begin
                    state_d = S_PRECHARGE;
                end
            end
            S_PRECHARGE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_RAMP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RAMP: begin
                if (tick) begin
                    cnt_d = '0;
                    // Target at or below the next step (including targets
                    // below PHI_START) lands exactly on the target.
                    if ({1'b0, i_phi_target} <= ramp_sum) begin
                        phi_d   = i_phi_target;
                        state_d = S_RUN;
                    end else begin
                        phi_d = ramp_sum[31:0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (tick) begin
                    cnt_d = '0;
                    if (diff_mag > PHI_STEP) begin
                        phi_d = diff[32] ? (phi_q - PHI_STEP) : (phi_q + PHI_STEP);
                    end else begin
                        phi_d = i_phi_target;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FAULT: begin
                phi_d = PHI_START;
                cnt_d = '0;
                if (!i_enable) begin
                    state_d = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    code_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                phi_d   = PHI_START;
                cnt_d   = '0;
                code_d  = 2'd0;
            end
        endcase

        // Operator abort: back to IDLE without a fault.
        if (active && !i_enable) begin
            state_d  = S_IDLE;
            phi_d    = PHI_START;
            cnt_d    = '0;
            oc_cnt_d = '0;
            or_cnt_d = '0;
        end

        // Faults override both the abort and normal sequencing.
        if (st_fault || oc_fault || or_fault) begin
            state_d  = S_FAULT;
            phi_d    = PHI_START;
            cnt_d    = '0;
            oc_cnt_d = '0;
            or_cnt_d = '0;
            if (st_fault) begin
                code_d = 2'd2;
            end else if (oc_fault) begin
                code_d = 2'd1;
            end else begin
                code_d = 2'd3;
            end
        end

        gate_d  = (state_d == S_RAMP) || (state_d == S_RUN);
        fault_d = (state_d == S_FAULT) || (state_d == S_COOLDOWN);
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            oc_cnt_q <= '0;
            or_cnt_q <= '0;
            phi_q    <= PHI_START;
            code_q   <= 2'd0;
            gate_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            oc_cnt_q <= oc_cnt_d;
            or_cnt_q <= or_cnt_d;
            phi_q    <= phi_d;
            code_q   <= code_d;
            gate_q   <= gate_d;
            fault_q  <= fault_d;
        end
    end

    assign o_phi32      = phi_q;
    assign o_gate_en    = gate_q;
    assign o_state      = state_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;

endmodule

// File: tb/tb_llc_softstart_sequencer.sv
// Testbench for llc_softstart_sequencer: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model of the sequencer.
module tb_llc_softstart_sequencer;

    localparam int P_START = 10;
    localparam int P_STEP  = 1;
    localparam int DIV     = 4;
    localparam int PRE     = 8;
    localparam int FILT    = 4;
    localparam int COOL    = 16;
    localparam int ILIM    = 6000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] target;
    logic [13:0] iC;
    logic        alert_n;
    logic        adc_or;
    logic [31:0] phi;
    logic        gate;
    logic [2:0]  st;
    logic        flt;
    logic [1:0]  code;

    llc_softstart_sequencer #(
        .PHI_START       (32'd10),
        .PHI_STEP        (32'd1),
        .RAMP_DIV        (DIV),
        .PRECHARGE_CYCLES(PRE),
        .I_LIMIT         (14'd6000),
        .FAULT_FILTER    (FILT),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .i_clock     (clk),
        .i_RESET     (rst_n),
        .i_enable    (en),
        .i_phi_target(target),
        .i_iC        (iC),
        .i_alert_n   (alert_n),
        .i_adc_or    (adc_or),
        .o_phi32     (phi),
        .o_gate_en   (gate),
        .o_state     (st),
        .o_fault     (flt),
        .o_fault_code(code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_en = 1'b0;
    int  cyc_no = 0;

    // Behavioural model: mode, cycles spent in the current phase, run lengths
    // of the two filtered fault conditions.
    int     m_mode;
    int     m_age;
    longint m_phi;
    int     m_code;
    int     m_oc_run;
    int     m_or_run;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_phi = P_START; m_code = 0; m_oc_run = 0; m_or_run = 0;
    endtask

    task automatic model_step();
        bit     act;
        int     icv, mag, fcode;
        longint d;
        act = (m_mode >= 1 && m_mode <= 3);
        icv = int'($signed(iC));
        mag = (icv < 0) ? -icv : icv;
        if (mag > 8191) mag = 8191;
        if (act) begin
            m_oc_run = (mag > ILIM) ? m_oc_run + 1 : 0;
            m_or_run = adc_or ? m_or_run + 1 : 0;
        end else begin
            m_oc_run = 0;
            m_or_run = 0;
        end
        fcode = 0;
        if (act) begin
            if (!alert_n)              fcode = 2;
            else if (m_oc_run >= FILT) fcode = 1;
            else if (m_or_run >= FILT) fcode = 3;
        end
        if (fcode != 0) begin
            m_mode = 4; m_code = fcode; m_phi = P_START; m_oc_run = 0; m_or_run = 0;
            return;
        end
        if (act && !en) begin
            m_mode = 0; m_phi = P_START; m_oc_run = 0; m_or_run = 0;
            return;
        end
        case (m_mode)
            0: if (en) begin m_mode = 1; m_age = 0; end
            1: begin
                m_age++;
                if (m_age == PRE) begin m_mode = 2; m_age = 0; end
            end
            2, 3: begin
                m_age++;
                if (m_age % DIV == 0) begin
                    d = longint'(target) - m_phi;
                    if (m_mode == 2) begin
                        if (d <= P_STEP) begin m_phi = target; m_mode = 3; end
                        else m_phi = m_phi + P_STEP;
                    end else begin
                        if (d > P_STEP)       m_phi = m_phi + P_STEP;
                        else if (d < -P_STEP) m_phi = m_phi - P_STEP;
                        else                  m_phi = target;
                    end
                end
            end
            4: if (!en) begin m_mode = 5; m_age = 0; end
            5: begin
                m_age++;
                if (m_age == COOL) begin m_mode = 0; m_code = 0; end
            end
            default: m_mode = 0;
        endcase
    endtask

    // One clock: DUT and model both consume the inputs at the posedge,
    // control returns at the following negedge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int maxc, input string name);
        int n = 0;
        while (st != 3'(s) && n < maxc) begin
            cyc();
            n++;
        end
        chk(name, st, s);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", st, m_mode);
            chk("phi", phi, m_phi);
            chk("gate_en", gate, (m_mode == 2 || m_mode == 3) ? 1 : 0);
            chk("fault", flt, (m_mode >= 4) ? 1 : 0);
            chk("fault_code", code, m_code);
        end
    end

    initial begin
        int n;
        int v, mag;
        bit oc_mode, or_mode;

        rst_n = 1'b0; en = 1'b0; target = 32'd15; iC = '0; alert_n = 1'b1; adc_or = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset state", st, 0);
        chk("reset phi", phi, 10);
        chk("reset gate", gate, 0);
        chk("reset fault", flt, 0);
        chk("reset code", code, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        $display("txn reset: state=%0d phi=%0d", st, phi);

        // Nominal start to target 15.
        en = 1'b1; target = 32'd15;
        n = 0;
        while (!gate && n < 50) begin cyc(); n++; end
        chk("gate rise edges", n, 9);
        n = 0;
        while (st != 3'd3 && n < 100) begin cyc(); n++; end
        chk("ramp length", n, 20);
        chk("run phi", phi, 15);
        $display("txn start: gate after 9 edges expected, RUN phi=%0d", phi);

        // Slew down then back up in RUN.
        target = 32'd12;
        repeat (12) cyc();
        chk("slew down phi", phi, 12);
        target = 32'd15;
        repeat (12) cyc();
        chk("slew up phi", phi, 15);
        $display("txn slew: phi=%0d", phi);

        // Overcurrent filter: short burst of 3, gap, then 4.
        iC = 14'(-6001);
        repeat (3) cyc();
        iC = 14'd0;
        cyc();
        chk("oc short burst state", st, 3);
        iC = 14'd6001;
        repeat (3) cyc();
        chk("oc 3 hits state", st, 3);
        cyc();
        chk("oc fault state", st, 4);
        chk("oc fault code", code, 1);
        chk("oc gate off", gate, 0);
        iC = 14'd0;
        $display("txn overcurrent: state=%0d code=%0d", st, code);

        // Fault exit: enable held, then dropped, cooldown, restart.
        repeat (20) cyc();
        chk("fault holds", st, 4);
        en = 1'b0;
        cyc();
        chk("cooldown entry", st, 5);
        n = 0;
        while (st == 3'd5 && n < 100) begin cyc(); n++; end
        chk("cooldown length", n, 16);
        chk("idle fault clear", flt, 0);
        en = 1'b1;
        cyc();
        chk("restart precharge", st, 1);
        $display("txn fault exit: state=%0d", st);

        // Shoot-through with simultaneous over-range in RAMP.
        wait_state(2, 40, "reach ramp");
        cyc();
        alert_n = 1'b0; adc_or = 1'b1;
        cyc();
        alert_n = 1'b1; adc_or = 1'b0;
        chk("st fault state", st, 4);
        chk("st fault code", code, 2);
        $display("txn shoot-through: code=%0d", code);

        // Clear the fault and restart into RAMP, then reset asynchronously.
        en = 1'b0;
        wait_state(0, 40, "back to idle");
        en = 1'b1;
        wait_state(2, 40, "reach ramp again");
        cyc();
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset gate", gate, 0);
        chk("async reset state", st, 0);
        chk("async reset phi", phi, 10);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        $display("txn async reset: gate=%0d state=%0d", gate, st);

        // Randomized operation against the model.
        oc_mode = 1'b0; or_mode = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 99) < 4) target = 32'($urandom_range(0, 30));
            if (!oc_mode && $urandom_range(0, 99) < 3) oc_mode = 1'b1;
            else if (oc_mode && $urandom_range(0, 99) < 20) oc_mode = 1'b0;
            if (!or_mode && $urandom_range(0, 99) < 3) or_mode = 1'b1;
            else if (or_mode && $urandom_range(0, 99) < 20) or_mode = 1'b0;
            if (oc_mode) begin
                mag = int'($urandom_range(5995, 8192));
                if ($urandom_range(0, 1) == 1) v = -mag;
                else v = (mag > 8191) ? 8191 : mag;
            end else begin
                v = int'($urandom_range(0, 200)) - 100;
            end
            iC = 14'(v);
            adc_or = or_mode && ($urandom_range(0, 3) != 0);
            alert_n = ($urandom_range(0, 399) != 0);
            cyc();
        end
        $display("txn random: 3000 cycles");

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/llc_softstart_sequencer.md
# llc_softstart_sequencer

Start-up and protection sequencer for the LLC half-bridge hybrid controller. It sits between the debounced enable switch and phi selector on one side and the hybrid control law and dead-time stage on the other. It owns the converter gate-enable and the phi command. It runs a precharge delay, then a slew-limited phi ramp to the operator target. It supervises the capacitor current, shoot-through flag and ADC over-range, and latches any fault until the operator drops enable and a cooldown expires.

## Interface
- PHI_START, 32'd10: phi command (centiradians) at ramp start and in all non-running states
- PHI_STEP, 32'd1: max phi change per ramp tick
- RAMP_DIV, 100000: cycles per ramp tick (1 ms at 100 MHz); must be ≥ 1
- PRECHARGE_CYCLES, 1000: cycles in PRECHARGE with gates off; must be ≥ 1
- I_LIMIT, 14'd6000: overcurrent threshold on |iC| (ADC counts)
- FAULT_FILTER, 4: consecutive samples required for overcurrent / over-range fault; must be ≥ 1
- COOLDOWN_CYCLES, 100000: cycles in COOLDOWN before returning to IDLE; must be ≥ 1
- i_clock  in  1  system clock, 100 MHz; the single clock of the block
- i_RESET  in  1  asynchronous, active-low reset
- i_enable  in  1  debounced converter enable (switch 0)
- i_phi_target  in  32  unsigned operator phi target (centiradians)
- i_iC  in  14  signed two's-complement resonant current sample
- i_alert_n  in  1  shoot-through flag, low = Q1&Q3 or Q2&Q4 overlap
- i_adc_or  in  1  OR of ADC A/B out-of-range flags
- o_phi32  out  32  phi command to hybrid control law
- o_gate_en  out  1  MOSFET enable, ANDed into gate drive
- o_state  out  3  IDLE=0, PRECHARGE=1, RAMP=2, RUN=3, FAULT=4, COOLDOWN=5
- o_fault  out  1  latched fault indicator
- o_fault_code  out  2  0 none, 1 overcurrent, 2 shoot-through, 3 ADC over-range

## Operation
- All outputs are registered. Reset values: o_state=IDLE, o_phi32=PHI_START, o_gate_en=0, o_fault=0, o_fault_code=0, all counters 0.
- IDLE: gates off and phi=PHI_START. If i_enable=1, go to PRECHARGE.
- PRECHARGE: gates off. After PRECHARGE_CYCLES cycles, go to RAMP, reset the tick counter and set o_gate_en=1.
- RAMP: every RAMP_DIV cycles, phi = min(phi+PHI_STEP, target). When phi==target, go to RUN. If target ≤ PHI_START, phi takes the target value on the first tick and the block enters RUN.
- RUN: gates on. On each tick, phi moves toward the current target by at most PHI_STEP, in either direction. Compute the difference in 33 bits so the step never overshoots or wraps.
- Enable low in PRECHARGE, RAMP or RUN: go to IDLE on the next edge, with gates off and phi=PHI_START. No fault is raised.
- Fault detection is active in PRECHARGE, RAMP and RUN:
  - Shoot-through: i_alert_n=0 on any single sample.
  - Overcurrent: |i_iC| > I_LIMIT (strict) for FAULT_FILTER consecutive samples. |-8192| saturates to 8191.
  - Over-range: i_adc_or=1 for FAULT_FILTER consecutive samples.
  - Each filter counter clears on any sample that does not meet its condition, and on entry to IDLE.
- Simultaneous faults: priority is shoot-through > overcurrent > over-range. Fault detection takes priority over enable-low and over state advancement in the same cycle.
- FAULT: gates off, phi=PHI_START, o_fault=1, code latched. Stay until i_enable=0, then go to COOLDOWN. New faults do not change the code.
- COOLDOWN: wait COOLDOWN_CYCLES cycles, then go to IDLE and clear o_fault and o_fault_code. Enable high during COOLDOWN has no effect. Enable already high on IDLE entry starts PRECHARGE on the next edge.
- Asynchronous reset mid-operation drops o_gate_en immediately (not clock-qualified) and restores all reset values.

## Timing
- Input sampled at edge k takes effect in the registered outputs after edge k, i.e. one-cycle latency.
- IDLE to RAMP with enable steady: o_gate_en rises PRECHARGE_CYCLES+1 edges after enable is first sampled high.
- First ramp step: RAMP_DIV cycles after RAMP entry. RAMP duration is ceil((target-PHI_START)/PHI_STEP) ticks.
- Shoot-through: o_gate_en=0 and o_state=FAULT after the sampling edge (one cycle).
- Overcurrent and over-range: fault asserted after the edge that samples the FAULT_FILTER-th consecutive hit.
- COOLDOWN lasts exactly COOLDOWN_CYCLES cycles.

## Test plan
Bench parameters: PHI_START=10, PHI_STEP=1, RAMP_DIV=4, PRECHARGE_CYCLES=8, FAULT_FILTER=4, COOLDOWN_CYCLES=16, I_LIMIT=6000.
- Nominal start: enable=1, target=15 -> o_gate_en rises 9 edges later; phi steps 11..15 every 4 cycles; o_state=RUN when phi=15.
- RUN slew: target changes 15->12 -> phi steps 14, 13, 12 on successive ticks; target=15 exactly, with no overshoot or wrap.
- Overcurrent filter: iC=-6001 for 3 cycles then 0, then iC=+6001 for 4 cycles -> first burst gives no fault; second gives FAULT with code=1 after the 4th edge and gates off.
- Shoot-through with simultaneous over-range: i_alert_n=0 for 1 cycle while i_adc_or=1 in RAMP -> code=2 next edge.
- Fault exit: in FAULT, hold enable=1 for 20 cycles (stays FAULT); drop enable -> COOLDOWN for 16 cycles; IDLE with o_fault=0; raise enable -> new PRECHARGE.
- Reset mid-RAMP: i_RESET=0 asynchronously -> o_gate_en=0 before the next edge, phi=10, state=IDLE.
